// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register map,
// STATUS field layout, unmapped read pattern and address region type.
package dmem_pkg;

  localparam logic [5:0] OFF_CONSOLE_TX = 6'h00;
  localparam logic [5:0] OFF_STATUS     = 6'h04;
  localparam logic [5:0] OFF_CYCLE_LO   = 6'h08;
  localparam logic [5:0] OFF_CYCLE_HI   = 6'h0C;
  localparam logic [5:0] OFF_HALT       = 6'h10;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;

  localparam logic [31:0] UNMAPPED_READ = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_t;

  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic ovf, input logic [3:0] count);
    logic [31:0] word;
    word = 32'h0000_0000;
    word[STATUS_FULL_BIT]  = full;
    word[STATUS_EMPTY_BIT] = empty;
    word[STATUS_OVF_BIT]   = ovf;
    word[STATUS_COUNT_LSB +: 4] = count;
    return word;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO for console bytes. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is dropped and flagged.
module console_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == CNT_W'(0));
  assign full      = (count_r == CNT_W'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dropped   = push && !do_push_s;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array, written at the tail; contents need no reset.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-enabled RAM plus MMIO window (console FIFO,
// cycle counter, halt). Macro DMEM_CYCLE_COUNTER_EN builds the cycle counter.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = 32'h0001_0000,
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_write_data,
  input  logic [3:0]  dmem_byte_enable,
  input  logic        dmem_read,
  input  logic        dmem_write,
  output logic [31:0] dmem_read_data,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        access_fault
);

  localparam int          IDX_W   = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + (33'(RAM_WORDS) * 33'd4);

  logic [31:0]             ram_r [RAM_WORDS];
  region_t                 region_s;
  logic [IDX_W-1:0]        ram_idx_s;
  logic [5:0]              mmio_off_s;
  logic                    store_ok_s;
  logic                    ram_we_s;
  logic                    mmio_we_s;
  logic                    fifo_push_s;
  logic                    fifo_pop_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic                    fifo_dropped_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
  logic                    fault_s;
  logic [31:0]             mmio_rdata_s;
  logic [31:0]             cycle_lo_s;
  logic [31:0]             cycle_hi_s;
  logic                    halt_r;
  logic [31:0]             halt_code_r;
  logic                    ovf_r;
  logic                    fault_r;

  // Address decode; RAM takes priority should the windows ever overlap.
  always_comb begin
    region_s = REG_NONE;
    if (({1'b0, dmem_addr} >= {1'b0, RAM_BASE}) && ({1'b0, dmem_addr} < RAM_END)) begin
      region_s = REG_RAM;
    end else if (dmem_addr[31:6] == MMIO_BASE[31:6]) begin
      region_s = REG_MMIO;
    end else begin
      region_s = REG_NONE;
    end
  end

  assign ram_idx_s  = IDX_W'((dmem_addr - RAM_BASE) >> 2);
  assign mmio_off_s = dmem_addr[5:0];

  // Once halted every store is ignored, but faults are still reported.
  assign store_ok_s  = dmem_write && !halt_r;
  assign ram_we_s    = store_ok_s && (region_s == REG_RAM);
  assign mmio_we_s   = store_ok_s && (region_s == REG_MMIO);
  assign fifo_push_s = mmio_we_s && (mmio_off_s == OFF_CONSOLE_TX) && dmem_byte_enable[0];
  assign fifo_pop_s  = console_valid && console_ready;
  assign fault_s     = ((dmem_read || dmem_write) && (region_s == REG_NONE))
                     || (dmem_read && dmem_write)
                     || (dmem_write && (dmem_byte_enable == 4'b0000));

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_console_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data (dmem_write_data[7:0]),
    .pop       (fifo_pop_s),
    .head      (console_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s),
    .dropped   (fifo_dropped_s)
  );

  assign console_valid = !fifo_empty_s;

  // Byte-lane RAM write; same-cycle reads see the old word.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we_s && dmem_byte_enable[i]) begin
        ram_r[ram_idx_s][8*i +: 8] <= dmem_write_data[8*i +: 8];
      end
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [63:0] cycle_r;
  logic [31:0] hi_snap_r;

  // Free-running counter; a CYCLE_LO load snapshots the upper half for CYCLE_HI.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_r   <= 64'h0;
      hi_snap_r <= 32'h0;
    end else begin
      cycle_r <= cycle_r + 64'd1;
      if (dmem_read && (region_s == REG_MMIO) && (mmio_off_s == OFF_CYCLE_LO)) begin
        hi_snap_r <= cycle_r[63:32];
      end
    end
  end

  assign cycle_lo_s = cycle_r[31:0];
  assign cycle_hi_s = hi_snap_r;
`else
  assign cycle_lo_s = 32'h0;
  assign cycle_hi_s = 32'h0;
`endif

  // Combinational read path so loads complete in the request cycle.
  always_comb begin
    mmio_rdata_s   = 32'h0;
    dmem_read_data = 32'h0;
    case (mmio_off_s)
      OFF_STATUS:   mmio_rdata_s = pack_status(fifo_full_s, fifo_empty_s, ovf_r, 4'(fifo_count_s));
      OFF_CYCLE_LO: mmio_rdata_s = cycle_lo_s;
      OFF_CYCLE_HI: mmio_rdata_s = cycle_hi_s;
      default:      mmio_rdata_s = 32'h0;
    endcase
    if (dmem_read) begin
      case (region_s)
        REG_RAM:  dmem_read_data = ram_r[ram_idx_s];
        REG_MMIO: dmem_read_data = mmio_rdata_s;
        default:  dmem_read_data = UNMAPPED_READ;
      endcase
    end else begin
      dmem_read_data = 32'h0;
    end
  end

  // Halt latch (first write wins), sticky overflow and the fault pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      halt_r      <= 1'b0;
      halt_code_r <= 32'h0;
      ovf_r       <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      if (mmio_we_s && (mmio_off_s == OFF_HALT)) begin
        halt_r      <= 1'b1;
        halt_code_r <= dmem_write_data;
      end
      if (fifo_dropped_s) begin
        ovf_r <= 1'b1;
      end else if (mmio_we_s && (mmio_off_s == OFF_STATUS)) begin
        ovf_r <= 1'b0;
      end
      fault_r <= fault_s;
    end
  end

  assign halt         = halt_r;
  assign halt_code    = halt_code_r;
  assign access_fault = fault_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder; loads and console bytes
// are scored against expectation queues filled as stimulus is driven.
module tb_data_mem_responder;

  localparam logic [31:0] RAM_BASE  = 32'h0001_0000;
  localparam logic [31:0] MMIO_BASE = 32'hF000_0000;
  localparam logic [31:0] A_TX      = MMIO_BASE + 32'h00;
  localparam logic [31:0] A_STATUS  = MMIO_BASE + 32'h04;
  localparam logic [31:0] A_CYC_LO  = MMIO_BASE + 32'h08;
  localparam logic [31:0] A_CYC_HI  = MMIO_BASE + 32'h0C;
  localparam logic [31:0] A_HALT    = MMIO_BASE + 32'h10;

  logic        clock;
  logic        reset;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_write_data;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_read_data;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready;
  logic        halt;
  logic [31:0] halt_code;
  logic        access_fault;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd_exp_q [$];
  logic [7:0]  con_exp_q [$];

  data_mem_responder dut (
    .clock            (clock),
    .reset            (reset),
    .dmem_addr        (dmem_addr),
    .dmem_write_data  (dmem_write_data),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_read_data   (dmem_read_data),
    .console_data     (console_data),
    .console_valid    (console_valid),
    .console_ready    (console_ready),
    .halt             (halt),
    .halt_code        (halt_code),
    .access_fault     (access_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dmem_addr        = 32'h0;
    dmem_write_data  = 32'h0;
    dmem_byte_enable = 4'b0000;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    dmem_addr        = addr;
    dmem_write_data  = data;
    dmem_byte_enable = be;
    dmem_write       = 1'b1;
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    rd_exp_q.push_back(exp);
    dmem_addr = addr;
    dmem_read = 1'b1;
    #1;
    chk(tag, dmem_read_data, rd_exp_q.pop_front());
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic push_byte(input logic [7:0] b, input logic accepted);
    if (accepted) con_exp_q.push_back(b);
    store(A_TX, {24'h0, b}, 4'b0001);
  endtask

  task automatic drain(input string tag, input int n);
    console_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, {31'h0, console_valid}, 32'h1);
      if (con_exp_q.size() > 0) chk({tag, "_data"}, {24'h0, console_data}, {24'h0, con_exp_q.pop_front()});
      else chk({tag, "_underrun"}, 32'(con_exp_q.size()), 32'h1);
      @(posedge clock);
      #1;
    end
    console_ready = 1'b0;
    chk({tag, "_empty_after"}, {31'h0, console_valid}, 32'h0);
  endtask

  initial begin
    idle();
    console_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", {31'h0, console_valid}, 32'h0);
    chk("rst_halt", {31'h0, halt}, 32'h0);
    chk("rst_code", halt_code, 32'h0);
    chk("rst_fault", {31'h0, access_fault}, 32'h0);
    chk("idle_rdata", dmem_read_data, 32'h0);
    reset = 1'b0;
    load("rst_status", A_STATUS, 32'h0000_0002);

    // RAM byte lanes
    store(RAM_BASE + 32'h4, 32'hAABB_CCDD, 4'b1111);
    store(RAM_BASE + 32'h4, 32'h0000_1100, 4'b0010);
    load("ram_be", RAM_BASE + 32'h4, 32'hAABB_11DD);
    chk("ram_nofault", {31'h0, access_fault}, 32'h0);
    load("ram_lowbits", RAM_BASE + 32'h6, 32'hAABB_11DD);

    // Read and write in one cycle: old data returned, write done, fault raised
    dmem_addr = RAM_BASE + 32'h4; dmem_write_data = 32'h0000_00EE;
    dmem_byte_enable = 4'b0001; dmem_read = 1'b1; dmem_write = 1'b1;
    #1;
    chk("rw_old", dmem_read_data, 32'hAABB_11DD);
    @(posedge clock);
    #1;
    idle();
    chk("rw_fault", {31'h0, access_fault}, 32'h1);
    load("rw_new", RAM_BASE + 32'h4, 32'hAABB_11EE);

    store(RAM_BASE + 32'h4, 32'hFFFF_FFFF, 4'b0000);
    chk("be0_fault", {31'h0, access_fault}, 32'h1);
    load("be0_nowrite", RAM_BASE + 32'h4, 32'hAABB_11EE);

    // RAM boundary and unmapped
    store(RAM_BASE + 32'h0FFC, 32'h5A5A_5A5A, 4'b1111);
    load("ram_last", RAM_BASE + 32'h0FFC, 32'h5A5A_5A5A);
    chk("ram_last_nofault", {31'h0, access_fault}, 32'h0);
    load("ram_end", RAM_BASE + 32'h1000, 32'hDEAD_BEEF);
    chk("ram_end_fault", {31'h0, access_fault}, 32'h1);
    load("unmapped", 32'h0000_0000, 32'hDEAD_BEEF);
    chk("unm_fault", {31'h0, access_fault}, 32'h1);
    @(posedge clock);
    #1;
    chk("unm_fault_pulse", {31'h0, access_fault}, 32'h0);
    load("mmio_other", MMIO_BASE + 32'h14, 32'h0);
    chk("mmio_other_nofault", {31'h0, access_fault}, 32'h0);

    // FIFO overflow and ordered drain
    for (int i = 0; i < 9; i++) push_byte(8'(8'h41 + i), i < 8);
    load("ovf_status", A_STATUS, 32'h0000_0805);
    drain("drain1", 8);
    store(A_STATUS, 32'h0, 4'b1111);
    load("ovf_clear", A_STATUS, 32'h0000_0002);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_byte(8'(8'h50 + i), 1'b1);
    console_ready = 1'b1;
    dmem_addr = A_TX; dmem_write_data = 32'h0000_0058;
    dmem_byte_enable = 4'b0001; dmem_write = 1'b1;
    #1;
    chk("pp_head", {24'h0, console_data}, {24'h0, con_exp_q.pop_front()});
    con_exp_q.push_back(8'h58);
    @(posedge clock);
    #1;
    idle();
    console_ready = 1'b0;
    load("pp_status", A_STATUS, 32'h0000_0801);
    drain("drain2", 8);

`ifdef DMEM_CYCLE_COUNTER_EN
    force dut.cycle_r = 64'h0000_0000_FFFF_FFFF;
    dmem_addr = A_CYC_LO;
    dmem_read = 1'b1;
    #1;
    chk("cyc_lo", dmem_read_data, 32'hFFFF_FFFF);
    @(posedge clock);
    #1;
    idle();
    release dut.cycle_r;
    load("cyc_hi_snap", A_CYC_HI, 32'h0);
`else
    load("cyc_lo_off", A_CYC_LO, 32'h0);
    chk("cyc_lo_nofault", {31'h0, access_fault}, 32'h0);
    load("cyc_hi_off", A_CYC_HI, 32'h0);
`endif

    // Halt
    store(RAM_BASE, 32'hCAFE_F00D, 4'b1111);
    push_byte(8'h60, 1'b1);
    store(A_HALT, 32'h0000_0001, 4'b1111);
    chk("halt_set", {31'h0, halt}, 32'h1);
    chk("halt_code", halt_code, 32'h1);
    store(RAM_BASE, 32'h1234_5678, 4'b1111);
    load("halt_ram", RAM_BASE, 32'hCAFE_F00D);
    store(A_HALT, 32'h0000_0005, 4'b1111);
    chk("halt_first", halt_code, 32'h1);
    store(A_TX, 32'h0000_0061, 4'b0001);
    drain("halt_drain", 1);
    load("halt_status", A_STATUS, 32'h0000_0002);

    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst2_halt", {31'h0, halt}, 32'h0);
    chk("rst2_code", halt_code, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
